// File: rtl/alphacore.sv
// Single-cycle RV32I-subset core: combinational fetch from memInput, internal
// register file and word-addressed data memory, all state updated on rising clk.
module alphacore #(
   parameter int unsigned IMEM_WORDS = 256,
   parameter int unsigned DMEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] memInput [IMEM_WORDS],
   output logic [31:0] pc,
   input  logic [7:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned IDXW  = 8;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic [XLEN-1:0] regs [NREGS];
   logic [XLEN-1:0] dmem [DMEM_WORDS];

   logic [XLEN-1:0] instr;
   logic [IDXW-1:0] iidx;
   logic [6:0]      opcode;
   logic [4:0]      rd, rs1, rs2;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic [XLEN-1:0] pc_plus4;
   logic [IDXW-1:0] ld_idx, st_idx;
   logic [XLEN-1:0] ld_data;

   logic [XLEN-1:0] next_pc;
   logic            wb_en;
   logic [XLEN-1:0] wb_data;
   logic            dmem_we;
   logic [XLEN-1:0] alu_b;
   logic            alu_alt;
   logic [XLEN-1:0] alu_y;
   logic            take;
   logic            br_valid;

   // Fetch wraps modulo 1 KiB; words beyond the array read as a NOP.
   assign iidx  = pc[9:2];
   assign instr = (32'(iidx) < IMEM_WORDS) ? memInput[iidx] : '0;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign f3     = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign f7     = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   assign rs1_val  = (rs1 == 5'd0) ? '0 : regs[rs1];
   assign rs2_val  = (rs2 == 5'd0) ? '0 : regs[rs2];
   assign pc_plus4 = pc + 32'd4;

   // Address bits [1:0] are dropped; only the word index is kept.
   assign ld_idx  = IDXW'((rs1_val + imm_i) >> 2);
   assign st_idx  = IDXW'((rs1_val + imm_s) >> 2);
   assign ld_data = (32'(ld_idx) < DMEM_WORDS) ? dmem[ld_idx] : '0;

   assign dbg_data = (32'(dbg_addr) < DMEM_WORDS) ? dmem[dbg_addr] : '0;

   // Shared ALU for register-register and register-immediate forms.
   assign alu_b   = (opcode == OP_R) ? rs2_val : imm_i;
   assign alu_alt = (opcode == OP_R) ? f7[5] : (f7[5] & (f3 == 3'b101));

   always_comb begin
      alu_y = '0;
      case (f3)
         3'b000:  alu_y = alu_alt ? (rs1_val - alu_b) : (rs1_val + alu_b);
         3'b001:  alu_y = rs1_val << alu_b[4:0];
         3'b010:  alu_y = XLEN'($signed(rs1_val) < $signed(alu_b));
         3'b011:  alu_y = XLEN'(rs1_val < alu_b);
         3'b100:  alu_y = rs1_val ^ alu_b;
         3'b101:  alu_y = alu_alt ? XLEN'($signed(rs1_val) >>> alu_b[4:0])
                                  : (rs1_val >> alu_b[4:0]);
         3'b110:  alu_y = rs1_val | alu_b;
         default: alu_y = rs1_val & alu_b;
      endcase
   end

   always_comb begin
      take     = 1'b0;
      br_valid = 1'b1;
      case (f3)
         3'b000:  take = (rs1_val == rs2_val);
         3'b001:  take = (rs1_val != rs2_val);
         3'b100:  take = ($signed(rs1_val) <  $signed(rs2_val));
         3'b101:  take = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110:  take = (rs1_val <  rs2_val);
         3'b111:  take = (rs1_val >= rs2_val);
         default: br_valid = 1'b0;
      endcase
   end

   // Decode/execute; anything not matched below falls through as a NOP.
   always_comb begin
      next_pc = pc_plus4;
      wb_en   = 1'b0;
      wb_data = '0;
      dmem_we = 1'b0;
      case (opcode)
         OP_R: begin
            if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))) begin
               wb_en   = 1'b1;
               wb_data = alu_y;
            end
         end
         OP_I: begin
            if (!((f3 == 3'b001 && f7 != F7_BASE) ||
                  (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT))) begin
               wb_en   = 1'b1;
               wb_data = alu_y;
            end
         end
         OP_LUI: begin
            wb_en   = 1'b1;
            wb_data = imm_u;
         end
         OP_AUIPC: begin
            wb_en   = 1'b1;
            wb_data = pc + imm_u;
         end
         OP_LOAD: begin
            if (f3 == 3'b010) begin
               wb_en   = 1'b1;
               wb_data = ld_data;
            end
         end
         OP_STORE: begin
            if (f3 == 3'b010) dmem_we = 1'b1;
         end
         OP_BRANCH: begin
            if (br_valid && take) next_pc = pc + imm_b;
         end
         OP_JAL: begin
            wb_en   = 1'b1;
            wb_data = pc_plus4;
            next_pc = pc + imm_j;
         end
         OP_JALR: begin
            if (f3 == 3'b000) begin
               wb_en   = 1'b1;
               wb_data = pc_plus4;
               next_pc = (rs1_val + imm_i) & ~32'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= '0;
      else        pc <= next_pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
      end else if (wb_en && rd != 5'd0) begin
         regs[rd] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DMEM_WORDS); i++) dmem[i] <= '0;
      end else if (dmem_we && 32'(st_idx) < DMEM_WORDS) begin
         dmem[st_idx] <= rs2_val;
      end
   end

endmodule

// File: tb/tb_alphacore.sv
// Directed bench for alphacore: loads small programs into the instruction array
// and checks pc / data memory against a queue of expected values.
module tb_alphacore;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imem [256];
   logic [31:0] pc;
   logic [7:0]  dbg_addr = 8'd0;
   logic [31:0] dbg_data;

   int tests = 0;
   int fails = 0;
   int pidx  = 0;

   logic [31:0] exp_q [$];
   string       tag_q [$];

   alphacore #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .memInput (imem),
      .pc       (pc),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
      logic [31:0] a, b, c, d, e;
      a = imm; b = rs1; c = f3; d = rd; e = op;
      return {a[11:0], b[4:0], c[2:0], d[4:0], e[6:0]};
   endfunction

   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
      logic [31:0] a, b, c, d, e;
      a = f7; b = rs2; c = rs1; d = f3; e = rd;
      return {a[6:0], b[4:0], c[4:0], d[2:0], e[4:0], 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
      logic [31:0] a, b, c;
      a = imm; b = rs2; c = rs1;
      return {a[11:5], b[4:0], c[4:0], 3'b010, a[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
      logic [31:0] a, b, c, d;
      a = imm; b = rs2; c = rs1; d = f3;
      return {a[12], a[10:5], b[4:0], c[4:0], d[2:0], a[4:1], a[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_u(int imm20, int rd, int op);
      logic [31:0] a, b, c;
      a = imm20; b = rd; c = op;
      return {a[19:0], b[4:0], c[6:0]};
   endfunction

   function automatic logic [31:0] enc_j(int imm, int rd);
      logic [31:0] a, b;
      a = imm; b = rd;
      return {a[20], a[10:1], a[11], a[19:12], b[4:0], 7'b1101111};
   endfunction

   function automatic logic [31:0] addi(int rd, int rs1, int imm);
      return enc_i(imm, rs1, 0, rd, 7'h13);
   endfunction

   task automatic emit(input logic [31:0] w);
      imem[pidx] = w;
      pidx++;
   endtask

   task automatic push(input string t, input logic [31:0] v);
      tag_q.push_back(t);
      exp_q.push_back(v);
   endtask

   task automatic check(input logic [31:0] obs);
      logic [31:0] e;
      string       t;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL scoreboard_empty: observed %h with no expectation queued", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
         end
      end
   endtask

   task automatic check_mem(input logic [7:0] a);
      dbg_addr = a;
      #1;
      check(dbg_data);
   endtask

   // Hold reset and clear the instruction array to all-zero (NOP) words.
   task automatic begin_prog();
      rst_n = 1'b0;
      for (int i = 0; i < 256; i++) imem[i] = 32'h0;
      pidx = 0;
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_to_pc(input logic [31:0] target, input int budget);
      int n;
      n = 0;
      while (pc !== target && n < budget) begin
         step(1);
         n++;
      end
   endtask

   task automatic load_sort();
      int vals [10];
      vals = '{6, 7, 2, 3, 1, 0, 4, 6, 9, 8};
      begin_prog();
      for (int i = 0; i < 10; i++) begin
         emit(addi(1, 0, vals[i]));
         emit(enc_s(4 * i, 1, 0));
      end
      emit(addi(5, 0, 9));                 // 80
      emit(addi(6, 0, 0));                 // 84 outer
      emit(addi(7, 5, 0));                 // 88
      emit(enc_i(0, 6, 2, 1, 7'h03));      // 92 inner: lw x1,0(x6)
      emit(enc_i(4, 6, 2, 2, 7'h03));      // 96 lw x2,4(x6)
      emit(enc_r(0, 2, 1, 2, 3));          // 100 slt x3,x1,x2
      emit(enc_b(12, 0, 3, 0));            // 104 beq x3,x0,+12
      emit(enc_s(0, 2, 6));                // 108 sw x2,0(x6)
      emit(enc_s(4, 1, 6));                // 112 sw x1,4(x6)
      emit(addi(6, 6, 4));                 // 116
      emit(addi(7, 7, -1));                // 120
      emit(enc_b(-32, 0, 7, 1));           // 124 bne x7,x0,inner
      emit(addi(5, 5, -1));                // 128
      emit(enc_b(-48, 0, 5, 1));           // 132 bne x5,x0,outer
      emit(enc_j(0, 0));                   // 136 halt
   endtask

   initial begin
      int sorted [10];
      sorted = '{9, 8, 7, 6, 6, 4, 3, 2, 1, 0};

      // Power-on reset state
      begin_prog();
      @(negedge clk);
      push("reset_pc", 32'h0);
      check(pc);
      push("reset_dmem0", 32'h0);
      check_mem(8'd0);

      // addi x14,x0,6 ; sw x14,0(x0)
      begin_prog();
      emit(addi(14, 0, 6));
      emit(enc_s(0, 14, 0));
      push("store6_pc", 32'd8);
      push("store6_dmem0", 32'd6);
      release_rst();
      step(2);
      check(pc);
      check_mem(8'd0);

      // x0 writes discarded
      begin_prog();
      emit(addi(1, 0, 99));
      emit(enc_s(0, 1, 0));
      emit(addi(0, 0, 5));
      emit(enc_r(0, 0, 0, 0, 1));
      emit(enc_s(0, 1, 0));
      push("x0_pre_dmem0", 32'd99);
      push("x0_dmem0", 32'd0);
      push("x0_pc", 32'd20);
      release_rst();
      step(2);
      check_mem(8'd0);
      step(3);
      check_mem(8'd0);
      check(pc);

      // Taken / not-taken branches
      begin_prog();
      emit(enc_b(8, 0, 0, 0));             // 0 beq x0,x0,+8
      emit(addi(9, 0, 1));                 // 4 skipped
      emit(addi(1, 0, -1));                // 8
      emit(enc_b(8, 1, 0, 6));             // 12 bltu x0,x1,+8 taken
      emit(32'h0);                         // 16
      emit(enc_b(8, 1, 0, 4));             // 20 blt x0,x1,+8 not taken
      push("beq_taken_pc", 32'd8);
      push("addi_pc", 32'd12);
      push("bltu_taken_pc", 32'd20);
      push("blt_not_taken_pc", 32'd24);
      release_rst();
      step(1); check(pc);
      step(1); check(pc);
      step(1); check(pc);
      step(1); check(pc);

      begin_prog();
      emit(enc_b(8, 0, 0, 1));             // bne x0,x0,+8
      push("bne_not_taken_pc", 32'd4);
      release_rst();
      step(1);
      check(pc);

      // jal / jalr linkage
      begin_prog();
      emit(32'h0);                         // 0
      emit(enc_j(16, 1));                  // 4 jal x1,+16
      emit(enc_s(0, 1, 0));                // 8 sw x1,0(x0)
      imem[5] = enc_i(0, 1, 0, 0, 7'h67);  // 20 jalr x0,0(x1)
      push("jal_pre_pc", 32'd4);
      push("jal_pc", 32'd20);
      push("jalr_pc", 32'd8);
      push("jal_link_dmem0", 32'd8);
      push("jal_post_pc", 32'd12);
      release_rst();
      step(1); check(pc);
      step(1); check(pc);
      step(1); check(pc);
      step(1); check_mem(8'd0);
      check(pc);

      // ALU, U-type, load, overflow wrap, misaligned address
      begin_prog();
      emit(enc_u(32'h80000, 1, 7'h37));    // lui x1,0x80000
      emit(enc_i(32'h404, 1, 5, 2, 7'h13));// srai x2,x1,4
      emit(enc_s(0, 2, 0));
      emit(enc_i(4, 1, 5, 3, 7'h13));      // srli x3,x1,4
      emit(enc_s(4, 3, 0));
      emit(enc_u(1, 4, 7'h17));            // auipc x4,1 at pc 20
      emit(enc_s(8, 4, 0));
      emit(addi(5, 0, -3));
      emit(addi(6, 0, 5));
      emit(enc_r(0, 6, 5, 2, 7));          // slt x7,x5,x6
      emit(enc_r(0, 5, 6, 3, 8));          // sltu x8,x6,x5
      emit(enc_r(32, 5, 6, 0, 9));         // sub x9,x6,x5
      emit(enc_s(12, 7, 0));
      emit(enc_s(16, 8, 0));
      emit(enc_s(20, 9, 0));
      emit(enc_i(20, 0, 2, 10, 7'h03));    // lw x10,20(x0)
      emit(enc_i(15, 10, 4, 10, 7'h13));   // xori x10,x10,15
      emit(enc_s(24, 10, 0));
      emit(enc_r(0, 6, 6, 1, 11));         // sll x11,x6,x6
      emit(enc_s(28, 11, 0));
      emit(enc_r(0, 1, 1, 0, 12));         // add x12,x1,x1 wraps to 0
      emit(addi(12, 12, 3));
      emit(enc_s(32, 12, 0));
      emit(enc_s(39, 6, 0));               // low address bits ignored
      push("alu_pc", 32'd96);
      push("srai", 32'hF800_0000);
      push("srli", 32'h0800_0000);
      push("auipc", 32'h0000_1014);
      push("slt", 32'd1);
      push("sltu", 32'd1);
      push("sub", 32'd8);
      push("lw_xori", 32'd7);
      push("sll", 32'd160);
      push("add_wrap", 32'd3);
      push("sw_misaligned", 32'd5);
      release_rst();
      step(24);
      check(pc);
      for (int i = 0; i < 10; i++) check_mem(8'(i));

      // Bubble sort to descending order
      load_sort();
      push("sort_halt_pc", 32'd136);
      for (int i = 0; i < 10; i++) push($sformatf("sort_word%0d", i), 32'(sorted[i]));
      release_rst();
      run_to_pc(32'd136, 1000);
      check(pc);
      for (int i = 0; i < 10; i++) check_mem(8'(i));

      // Asynchronous reset in the middle of the sort
      load_sort();
      release_rst();
      step(150);
      dbg_addr = 8'd0;
      #1;
      rst_n = 1'b0;
      #1;
      push("midreset_pc", 32'h0);
      push("midreset_dmem0", 32'h0);
      check(pc);
      check(dbg_data);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
